// File: rtl/sw_pkg.sv
// ============================================================================
// Module      : sw_pkg
// Description : Shared types and constants for the switch debounce stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sw_pkg;

   // Per-bit debounce FSM: idle on the accepted level, or timing a mismatch
   typedef enum logic [0:0] {
      DBS_STABLE  = 1'b0,
      DBS_PENDING = 1'b1
   } dbs_state_t;

   localparam int SW_WIDTH          = 4;
   localparam int SW_DB_CYCLES_5MHZ = 50000;  // 10 ms at 5 MHz
   localparam int DB_CNT_W          = $clog2(SW_DB_CYCLES_5MHZ);

endpackage : sw_pkg

`default_nettype wire

// File: rtl/sw_debounce_if.sv
// ============================================================================
// Module      : sw_debounce_if
// Description : Switch-pin input and conditioned-level outputs of the
//               debounce stage. The board/switch side is the master, the
//               debounce stage is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sw_debounce_if
   import sw_pkg::*;
#(
   parameter int WIDTH = SW_WIDTH
);

   logic [WIDTH-1:0] sw;
   logic [WIDTH-1:0] sw_db;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;
   logic             sw_changed;

   modport master (
      output sw,
      input  sw_db,
      input  sw_rise,
      input  sw_fall,
      input  sw_changed
   );

   modport slave (
      input  sw,
      output sw_db,
      output sw_rise,
      output sw_fall,
      output sw_changed
   );

endinterface : sw_debounce_if

`default_nettype wire

// File: rtl/sw_debounce_bit.sv
// ============================================================================
// Module      : sw_debounce_bit
// Description : One switch bit: two-flop synchronizer, STABLE/PENDING FSM
//               with stability counter, registered level and edge pulses.
//               The next-cycle pulse values are also exported so the top can
//               register its summary pulse on the same edge as the pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_debounce_bit
   import sw_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = SW_DB_CYCLES_5MHZ,
   parameter int CNT_W           = DB_CNT_W
) (
   input  wire logic clk_in,
   input  wire logic rst_n,
   input  wire logic i_sw,
   output logic      o_db,
   output logic      o_rise,
   output logic      o_fall,
   output logic      o_rise_nxt,
   output logic      o_fall_nxt
);

   // Count value at which a mismatch has persisted long enough to accept
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   logic             r_s1;
   logic             r_s2;
   dbs_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_db;
   logic             r_rise;
   logic             r_fall;

   dbs_state_t       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_db_nxt;
   logic             w_rise_nxt;
   logic             w_fall_nxt;

   // Synchronizer chain; only r_s2 is ever looked at by the FSM
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_sw;
         r_s2 <= r_s1;
      end
   end

   // State, counter, accepted level and edge pulses
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= DBS_STABLE;
         r_cnt   <= '0;
         r_db    <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_db    <= w_db_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   // Next-state: any return to the accepted level abandons the pending change;
   // the compare against c_CNT_LAST keeps the counter from ever wrapping
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_db_nxt    = r_db;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
         DBS_STABLE: begin
            w_cnt_nxt = '0;
            if (r_s2 != r_db) begin
               w_state_nxt = DBS_PENDING;
               w_cnt_nxt   = c_CNT_ONE;
            end
         end
         DBS_PENDING: begin
            if (r_s2 == r_db) begin
               w_state_nxt = DBS_STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = DBS_STABLE;
               w_cnt_nxt   = '0;
               w_db_nxt    = r_s2;
               w_rise_nxt  = r_s2;
               w_fall_nxt  = ~r_s2;
            end else begin
               w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = DBS_STABLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_db       = r_db;
   assign o_rise     = r_rise;
   assign o_fall     = r_fall;
   assign o_rise_nxt = w_rise_nxt;
   assign o_fall_nxt = w_fall_nxt;

endmodule : sw_debounce_bit

`default_nettype wire

// File: rtl/sw_debounce.sv
// ============================================================================
// Module      : sw_debounce
// Description : Synchronizes and debounces WIDTH slide-switch inputs,
//               producing clean levels, per-bit rise/fall pulses and a
//               single any-change pulse, all registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_debounce
   import sw_pkg::*;
#(
   parameter int WIDTH           = SW_WIDTH,
   parameter int DEBOUNCE_CYCLES = SW_DB_CYCLES_5MHZ,
   parameter int CNT_W           = DB_CNT_W
) (
   input  wire logic      clk_in,
   input  wire logic      rst_n,
   sw_debounce_if.slave   bus
);

   logic [WIDTH-1:0] w_sw;
   logic [WIDTH-1:0] w_db;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_rise_nxt;
   logic [WIDTH-1:0] w_fall_nxt;
   logic             r_changed;

   assign w_sw = bus.sw;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_bit (
            .clk_in     (clk_in),
            .rst_n      (rst_n),
            .i_sw       (w_sw[gi]),
            .o_db       (w_db[gi]),
            .o_rise     (w_rise[gi]),
            .o_fall     (w_fall[gi]),
            .o_rise_nxt (w_rise_nxt[gi]),
            .o_fall_nxt (w_fall_nxt[gi])
         );
      end
   endgenerate

   // Summary pulse built from next-cycle pulse values so it lines up with them
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_changed <= 1'b0;
      end else begin
         r_changed <= |(w_rise_nxt | w_fall_nxt);
      end
   end

   assign bus.sw_db      = w_db;
   assign bus.sw_rise    = w_rise;
   assign bus.sw_fall    = w_fall;
   assign bus.sw_changed = r_changed;

endmodule : sw_debounce

`default_nettype wire
